// File: rtl/lane_change_queue.sv
// Purpose: records every change of a sampled lane vector as {mask, value, stamp} into an in-order FIFO.
// Latency: a change captured at an edge is visible on out_* the following cycle; there is no bypass path.
// Backpressure: out_valid/out_ready drain. When full with no pop, a record is dropped (sticky overflow,
//   saturating drop_count). If LANE_CHANGE_QUEUE_COALESCE_EN is defined, it is merged into the tail instead.
module lane_change_queue #(
  parameter int N     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_mask,
  output logic [N-1:0]             out_val,
  output logic [15:0]              out_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0]  r_prev;
  logic [15:0]   r_stamp;
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;
  logic [N-1:0]  r_mask_mem  [DEPTH];
  logic [N-1:0]  r_val_mem   [DEPTH];
  logic [15:0]   r_stamp_mem [DEPTH];

  logic [N-1:0]  w_chg;
  logic          w_push;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_drop;
  logic          w_merge;
  logic [AW-1:0] w_tail;
  logic [AW-1:0] w_head;

  assign w_chg   = in_vec ^ r_prev;
  assign w_push  = |w_chg;
  assign w_count = r_wr - r_rd;
  assign w_full  = (w_count == FULL_CNT);
  assign w_empty = (w_count == '0);
  assign w_pop   = ~w_empty & out_ready;
  // A pop on a full queue frees the slot the new record lands in, so it is a plain push.
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_tail  = r_wr[AW-1:0] - AW'(1);
  assign w_head  = r_rd[AW-1:0];

`ifdef LANE_CHANGE_QUEUE_COALESCE_EN
  // Full, no room: fold the change into the newest record rather than losing it.
  assign w_drop  = 1'b0;
  assign w_merge = w_push & w_full & ~w_pop;
`else
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_merge = 1'b0;
`endif

  // Sample history, timestamp, queue pointers and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_stamp    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_prev  <= in_vec;
      r_stamp <= r_stamp + 16'd1;
      if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)   r_rd <= r_rd + (AW+1)'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // Record storage; stale contents are masked at the output, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mask_mem[r_wr[AW-1:0]]  <= w_chg;
      r_val_mem[r_wr[AW-1:0]]   <= in_vec;
      r_stamp_mem[r_wr[AW-1:0]] <= r_stamp;
    end else if (w_merge) begin
      r_mask_mem[w_tail] <= r_mask_mem[w_tail] | w_chg;
      r_val_mem[w_tail]  <= in_vec;
    end
  end

  // Head presentation: zero whenever nothing is queued.
  always_comb begin
    out_valid = ~w_empty;
    out_mask  = '0;
    out_val   = '0;
    out_stamp = '0;
    if (~w_empty) begin
      out_mask  = r_mask_mem[w_head];
      out_val   = r_val_mem[w_head];
      out_stamp = r_stamp_mem[w_head];
    end
  end

  assign count      = w_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

endmodule
